// File: rtl/dr_pkg.sv
// Shared types and constants for the dual-rail RTZ driver: FSM states,
// rail encodings and the default synchronizer depth.
package dr_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_NULL = 2'd2,
      ERR       = 2'd3
   } dr_state_e;

   // {rail1, rail0}
   localparam logic [1:0] RAIL_NULL = 2'b00;
   localparam logic [1:0] RAIL_ERR  = 2'b11;

   localparam int DR_SYNC_STAGES = 2;

endpackage

// File: rtl/dr_sync.sv
// N-stage flop synchronizer for one asynchronous level, cleared to 0 by the
// asynchronous active-low reset.
module dr_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [N-1:0] r_ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ff <= '0;
      else        r_ff <= {r_ff[N-2:0], i_d};
   end

   assign o_q = r_ff[N-1];

endmodule

// File: rtl/dual_rail_rtz_driver.sv
// Clocked initiator for a dual-rail four-phase RTZ async datapath.
// Optional per-phase watchdog built when DR_TIMEOUT_EN is defined.
module dual_rail_rtz_driver
   import dr_pkg::*;
#(
   parameter int SYNC_STAGES = DR_SYNC_STAGES,
   parameter int TOKEN_CNT_W = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_valid,
   input  logic                   s_bit,
   output logic                   s_ready,
   output logic                   rail0,
   output logic                   rail1,
   input  logic                   ack0,
   input  logic                   ack1,
   output logic                   r_valid,
   output logic                   r_parity,
   output logic                   busy,
   output logic                   err_protocol,
   output logic                   err_timeout,
   output logic [TOKEN_CNT_W-1:0] tok_count
);

   localparam int INIT_W = $clog2(SYNC_STAGES + 1) + 1;
   localparam int SPUR_W = $clog2(SYNC_STAGES + 2) + 1;
   localparam logic [INIT_W-1:0] INIT_DONE = INIT_W'(SYNC_STAGES);
   localparam logic [SPUR_W-1:0] SPUR_LIM  = SPUR_W'(SYNC_STAGES + 1);

   dr_state_e               r_state;
   logic [1:0]              r_rails;
   logic                    r_ready;
   logic                    r_valid_q;
   logic                    r_parity_q;
   logic                    r_err_p;
   logic [TOKEN_CNT_W-1:0]  r_tok;
   logic [INIT_W-1:0]       r_init_cnt;
   logic                    r_seen_null;
   logic [SPUR_W-1:0]       r_spur_cnt;

   logic       w_sa0, w_sa1;
   logic [1:0] w_sa;
   logic       w_null, w_init_done, w_accept, w_to_hit;

   dr_sync #(.N(SYNC_STAGES)) u_sync0 (.clk(clk), .rst_n(rst_n), .i_d(ack0), .o_q(w_sa0));
   dr_sync #(.N(SYNC_STAGES)) u_sync1 (.clk(clk), .rst_n(rst_n), .i_d(ack1), .o_q(w_sa1));

   assign w_sa        = {w_sa1, w_sa0};
   assign w_null      = (w_sa == RAIL_NULL);
   // Synchronizers read as null right after reset; trust them only once filled.
   assign w_init_done = (r_init_cnt == INIT_DONE);
   assign w_accept    = s_valid && r_ready;

`ifdef DR_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
   logic [TO_W-1:0] r_to_cnt;
   logic            r_err_to;

   assign w_to_hit = ((r_state == WAIT_ACK) || (r_state == WAIT_NULL)) &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
         r_err_to <= 1'b0;
      end else begin
         if (w_to_hit) r_err_to <= 1'b1;
         if (w_accept || ((r_state == WAIT_ACK) && (w_sa0 ^ w_sa1)))
            r_to_cnt <= '0;
         else if ((r_state == WAIT_ACK) || (r_state == WAIT_NULL))
            r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign err_timeout = r_err_to;
`else
   assign w_to_hit    = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rails     <= RAIL_NULL;
         r_ready     <= 1'b0;
         r_valid_q   <= 1'b0;
         r_parity_q  <= 1'b0;
         r_err_p     <= 1'b0;
         r_tok       <= '0;
         r_init_cnt  <= '0;
         r_seen_null <= 1'b0;
         r_spur_cnt  <= '0;
      end else begin
         r_valid_q <= 1'b0;
         if (!w_init_done) r_init_cnt <= r_init_cnt + 1'b1;
         case (r_state)
            IDLE: begin
               if (!w_init_done) begin
                  r_ready <= 1'b0;
               end else if (w_accept) begin
                  r_rails <= s_bit ? 2'b10 : 2'b01;
                  r_ready <= 1'b0;
                  r_state <= WAIT_ACK;
               end else if (w_null) begin
                  r_seen_null <= 1'b1;
                  r_spur_cnt  <= '0;
                  r_ready     <= 1'b1;
               end else begin
                  // Ack held over from before reset is waited out, not flagged.
                  r_ready <= 1'b0;
                  if (r_seen_null) begin
                     if (r_spur_cnt == SPUR_LIM) begin
                        r_err_p <= 1'b1;
                        r_state <= ERR;
                     end else begin
                        r_spur_cnt <= r_spur_cnt + 1'b1;
                     end
                  end
               end
            end
            WAIT_ACK: begin
               if (w_to_hit) begin
                  r_rails <= RAIL_NULL;
                  r_state <= ERR;
               end else if (w_sa == RAIL_ERR) begin
                  r_rails <= RAIL_NULL;
                  r_err_p <= 1'b1;
                  r_state <= ERR;
               end else if (w_sa0 ^ w_sa1) begin
                  r_parity_q <= w_sa1;
                  r_valid_q  <= 1'b1;
                  r_rails    <= RAIL_NULL;
                  r_state    <= WAIT_NULL;
               end
            end
            WAIT_NULL: begin
               if (w_to_hit) begin
                  r_state <= ERR;
               end else if ((w_sa == RAIL_ERR) || (r_parity_q ? w_sa0 : w_sa1)) begin
                  r_err_p <= 1'b1;
                  r_state <= ERR;
               end else if (w_null) begin
                  r_tok      <= r_tok + 1'b1;
                  r_spur_cnt <= '0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_rails <= RAIL_NULL;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign rail0        = r_rails[0];
   assign rail1        = r_rails[1];
   assign s_ready      = r_ready;
   assign r_valid      = r_valid_q;
   assign r_parity     = r_parity_q;
   assign busy         = (r_state != IDLE);
   assign err_protocol = r_err_p;
   assign tok_count    = r_tok;

endmodule

// File: tb/tb_dual_rail_rtz_driver.sv
// Scoreboard bench for dual_rail_rtz_driver with a running-parity circuit model;
// covers the DR_TIMEOUT_EN build when that macro is defined.
module tb_dual_rail_rtz_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_bit = 1'b0;
   logic       s_ready, rail0, rail1, r_valid, r_parity, busy;
   logic       err_protocol, err_timeout;
   logic [1:0] tok_count;
   logic       ack0, ack1;

   logic manual = 1'b0;
   logic m0 = 1'b0, m1 = 1'b0;
   logic c0 = 1'b0, c1 = 1'b0;
   logic par = 1'b0;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int both_hi = 0;
   logic exp_q[$];

   assign ack0 = manual ? m0 : c0;
   assign ack1 = manual ? m1 : c1;

   always #5 clk = ~clk;

   dual_rail_rtz_driver #(
      .SYNC_STAGES(2), .TOKEN_CNT_W(2), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready),
      .rail0(rail0), .rail1(rail1), .ack0(ack0), .ack1(ack1), .r_valid(r_valid),
      .r_parity(r_parity), .busy(busy), .err_protocol(err_protocol),
      .err_timeout(err_timeout), .tok_count(tok_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Zero-delay circuit: result = running parity of all tokens so far.
   always @(negedge clk) begin
      if (!rst_n || manual) begin
         c0 = 1'b0; c1 = 1'b0;
      end else if ((rail0 || rail1) && !c0 && !c1) begin
         par = par ^ rail1;
         c1 = par; c0 = ~par;
      end else if (!rail0 && !rail1 && (c0 || c1)) begin
         c0 = 1'b0; c1 = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (rail0 && rail1) both_hi++;
         if (r_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_r_valid: got 1 expected 0");
            end else begin
               chk("r_parity", {31'd0, r_parity}, {31'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic wait_ready(input string name);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_ready) begin ok = 1; break; end
      end
      chk(name, {31'd0, ok}, 32'd1);
   endtask

   task automatic send(input logic b);
      wait_ready("s_ready_before_send");
      s_valid = 1'b1; s_bit = b;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   initial begin
      int  n;
      bit  saw_ready;
      logic [4:0] bits;
      logic [4:0] pars;
      bits = 5'b10110;   // issued LSB first: 0,1,1,0,1
      pars = 5'b10010;   // expected parity:   0,1,0,0,1

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rails", {30'd0, rail1, rail0}, 32'd0);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {30'd0, err_protocol, err_timeout}, 32'd0);
      chk("rst_tok", {30'd0, tok_count}, 32'd0);
      rst_n = 1'b1;

      // First token, latency and throughput
      exp_q.push_back(pars[0]);
      send(bits[0]);
      chk("rail0_after_accept", {30'd0, rail1, rail0}, 32'd1);
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      n = 0;
      while (!s_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("accept_to_ready_cycles", n, 32'd7);
      chk("rails_null_after_token", {30'd0, rail1, rail0}, 32'd0);
      chk("tok_after_1", {30'd0, tok_count}, 32'd1);

      // 1,1,0 then one more token: count wraps at 4
      for (int i = 1; i < 4; i++) begin
         exp_q.push_back(pars[i]);
         send(bits[i]);
      end
      wait_ready("ready_after_seq");
      chk("tok_after_4_wrap", {30'd0, tok_count}, 32'd0);
      exp_q.push_back(pars[4]);
      send(bits[4]);
      wait_ready("ready_after_5");
      chk("tok_after_5", {30'd0, tok_count}, 32'd1);
      chk("pulses_5", pulses, 32'd5);
      chk("both_rails_high", both_hi, 32'd0);

      // Illegal ack encoding during WAIT_ACK
      manual = 1'b1;
      send(1'b0);
      @(negedge clk); m0 = 1'b1; m1 = 1'b1;
      repeat (5) @(negedge clk);
      chk("err_protocol_set", {31'd0, err_protocol}, 32'd1);
      chk("err_rails_null", {30'd0, rail1, rail0}, 32'd0);
      m0 = 1'b0; m1 = 1'b0;
      saw_ready = 0;
      repeat (20) begin @(negedge clk); if (s_ready) saw_ready = 1; end
      chk("err_ready_held_low", {31'd0, saw_ready}, 32'd0);
      chk("err_protocol_sticky", {31'd0, err_protocol}, 32'd1);

      // Reset mid-handshake while rail1 is high, ack1 held across release
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("err_cleared_by_reset", {31'd0, err_protocol}, 32'd0);
      rst_n = 1'b1;
      send(1'b1);
      chk("rail1_high", {30'd0, rail1, rail0}, 32'd2);
      m1 = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rail1_async_clear", {31'd0, rail1}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_ready = 0;
      repeat (20) begin @(negedge clk); if (s_ready) saw_ready = 1; end
      chk("ready_low_while_ack1", {31'd0, saw_ready}, 32'd0);
      chk("no_spurious_err", {31'd0, err_protocol}, 32'd0);
      m1 = 1'b0;
      wait_ready("ready_after_ack1_drop");
      chk("tok_not_counted", {30'd0, tok_count}, 32'd0);

      // Missing ack: watchdog or indefinite wait
      send(1'b0);
`ifdef DR_TIMEOUT_EN
      n = 0;
      while (!err_timeout && n < 100) begin @(posedge clk); #1; n++; end
      chk("timeout_cycles", n, 32'd16);
      chk("timeout_rails_null", {30'd0, rail1, rail0}, 32'd0);
`else
      repeat (1000) @(negedge clk);
      chk("no_timeout", {31'd0, err_timeout}, 32'd0);
      chk("still_busy", {31'd0, busy}, 32'd1);
      chk("rail0_held", {30'd0, rail1, rail0}, 32'd1);
`endif
      chk("no_protocol_err_end", {31'd0, err_protocol}, 32'd0);
      chk("pulses_total", pulses, 32'd5);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
